// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned PC_W         = 32;
  localparam int unsigned IMEM_AW      = 21;
  localparam int unsigned INSTR_W      = 16;
  localparam int unsigned TWO_WORD_BIT = 15;

  // Reset vector: upper PC half lives at word 0, lower half at word 1.
  localparam logic [IMEM_AW-1:0] RESET_VEC_HI_ADDR = 21'd0;
  localparam logic [IMEM_AW-1:0] RESET_VEC_LO_ADDR = 21'd1;

  typedef enum logic [1:0] {
    RST_LO,
    RST_HI,
    FETCH,
    FETCH_IMM
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register bank. Priority: reset > hold > clear > load.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_hold,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [INSTR_W-1:0] i_imm,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [PC_W-1:0]    i_pc_next,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [INSTR_W-1:0] o_imm,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc_next
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_imm;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_pc_next;

  // Register bank update; clear only drops valid and leaves the payload as-is.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_pc_next <= '0;
    end else if (i_hold) begin
      r_valid   <= r_valid;
    end else if (i_clear) begin
      r_valid   <= 1'b0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_instr   <= i_instr;
      r_imm     <= i_imm;
      r_pc      <= i_pc;
      r_pc_next <= i_pc_next;
    end
  end

  assign o_valid   = r_valid;
  assign o_instr   = r_instr;
  assign o_imm     = r_imm;
  assign o_pc      = r_pc;
  assign o_pc_next = r_pc_next;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: boots PC from the reset vector, then fetches one- and
// two-word instructions into the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [INSTR_W-1:0] ifid_imm,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_next
);

  fetch_state_t       r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_saved_word;
  logic [PC_W-1:0]    r_saved_pc;

  fetch_state_t       w_state_next;
  logic [PC_W-1:0]    w_pc_next;
  logic [PC_W-1:0]    w_pc_inc;
  logic               w_save;
  logic               w_hold;
  logic               w_clear;
  logic               w_load;
  logic [INSTR_W-1:0] w_ld_instr;
  logic [INSTR_W-1:0] w_ld_imm;
  logic [PC_W-1:0]    w_ld_pc;

  assign w_pc_inc = r_pc + 32'd1;

  // State, PC and saved first-word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RST_LO;
      r_pc         <= '0;
      r_saved_word <= '0;
      r_saved_pc   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_save) begin
        r_saved_word <= imem_data;
        r_saved_pc   <= r_pc;
      end
    end
  end

  // Next-state, PC and IF/ID control; branch > flush > stall > normal.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_save       = 1'b0;
    w_hold       = 1'b0;
    w_clear      = 1'b0;
    w_load       = 1'b0;
    w_ld_instr   = imem_data;
    w_ld_imm     = '0;
    w_ld_pc      = r_pc;
    imem_addr    = r_pc[IMEM_AW-1:0];
    case (r_state)
      RST_LO: begin
        imem_addr    = RESET_VEC_HI_ADDR;
        w_pc_next    = {imem_data, r_pc[15:0]};
        w_clear      = 1'b1;
        w_state_next = RST_HI;
      end
      RST_HI: begin
        imem_addr    = RESET_VEC_LO_ADDR;
        w_pc_next    = {r_pc[31:16], imem_data};
        w_clear      = 1'b1;
        w_state_next = FETCH;
      end
      default: begin
        if (branch_taken) begin
          w_pc_next    = branch_target;
          w_clear      = 1'b1;
          w_state_next = FETCH;
        end else if (stall && !flush) begin
          w_hold = 1'b1;
        end else begin
          // Flush still advances fetch; the clear simply overrides the load.
          w_clear   = flush;
          w_pc_next = w_pc_inc;
          if (r_state == FETCH_IMM) begin
            w_ld_instr   = r_saved_word;
            w_ld_imm     = imem_data;
            w_ld_pc      = r_saved_pc;
            w_load       = 1'b1;
            w_state_next = FETCH;
          end else if (imem_data[TWO_WORD_BIT]) begin
            w_save       = 1'b1;
            w_clear      = 1'b1;
            w_state_next = FETCH_IMM;
          end else begin
            w_load = 1'b1;
          end
        end
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_hold    (w_hold),
    .i_clear   (w_clear),
    .i_load    (w_load),
    .i_instr   (w_ld_instr),
    .i_imm     (w_ld_imm),
    .i_pc      (w_ld_pc),
    .i_pc_next (w_pc_inc),
    .o_valid   (ifid_valid),
    .o_instr   (ifid_instr),
    .o_imm     (ifid_imm),
    .o_pc      (ifid_pc),
    .o_pc_next (ifid_pc_next)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 256-word instruction memory model
// (indexed by imem_addr[7:0]).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken;
  logic [31:0] branch_target;
  logic [20:0] imem_addr;
  logic [15:0] imem_data;
  logic        ifid_valid;
  logic [15:0] ifid_instr, ifid_imm;
  logic [31:0] ifid_pc, ifid_pc_next;

  logic [15:0] mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:0]];

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_imm      (ifid_imm),
    .ifid_pc       (ifid_pc),
    .ifid_pc_next  (ifid_pc_next)
  );

  typedef struct {
    logic        rst, stl, fls, br;
    logic [31:0] tgt;
    logic        valid;
    logic [15:0] instr, imm;
    logic [31:0] pc, pcn;
    logic [20:0] addr;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic rst, logic stl, logic fls, logic br, logic [31:0] tgt,
                              logic valid, logic [15:0] instr, logic [15:0] imm,
                              logic [31:0] pc, logic [31:0] pcn, logic [20:0] addr);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fls = fls; v.br = br; v.tgt = tgt;
    v.valid = valid; v.instr = instr; v.imm = imm; v.pc = pc; v.pcn = pcn; v.addr = addr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Apply inputs just after a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic rst, input logic stl, input logic fls, input logic br,
                      input logic [31:0] tgt);
    reset = rst; stall = stl; flush = fls; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic valid, input logic [15:0] instr,
                         input logic [15:0] imm, input logic [31:0] pc, input logic [31:0] pcn,
                         input logic [20:0] addr);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    chk({tag, ".instr"}, {16'd0, ifid_instr}, {16'd0, instr});
    chk({tag, ".imm"},   {16'd0, ifid_imm},   {16'd0, imm});
    chk({tag, ".pc"},    ifid_pc,  pc);
    chk({tag, ".pcn"},   ifid_pc_next, pcn);
    chk({tag, ".addr"},  {11'd0, imem_addr}, {11'd0, addr});
  endtask

  task automatic chk_va(input string tag, input logic valid, input logic [20:0] addr);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    chk({tag, ".addr"},  {11'd0, imem_addr}, {11'd0, addr});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h0000; mem[8'h01] = 16'h0010;
    mem[8'h10] = 16'h1234; mem[8'h11] = 16'h8001; mem[8'h12] = 16'hBEEF;
    mem[8'h13] = 16'h0A0A; mem[8'h20] = 16'h0020;
    mem[8'h40] = 16'h0042; mem[8'h41] = 16'h0043;
    mem[8'h42] = 16'h8005; mem[8'h43] = 16'h1111;
    mem[8'hFF] = 16'h0077;

    //              rst stl fls br  target        vld instr     imm       pc            pc_next       addr
    vecs[0]  = mk(1, 0, 0, 0, 32'h0,        0, 16'h0000, 16'h0000, 32'h0,        32'h0,        21'h0);
    vecs[1]  = mk(1, 1, 1, 1, 32'h55,       0, 16'h0000, 16'h0000, 32'h0,        32'h0,        21'h0);
    vecs[2]  = mk(0, 1, 0, 0, 32'h0,        0, 16'h0000, 16'h0000, 32'h0,        32'h0,        21'h1);
    vecs[3]  = mk(0, 0, 1, 1, 32'h77,       0, 16'h0000, 16'h0000, 32'h0,        32'h0,        21'h10);
    vecs[4]  = mk(0, 0, 0, 0, 32'h0,        1, 16'h1234, 16'h0000, 32'h10,       32'h11,       21'h11);
    vecs[5]  = mk(0, 0, 0, 0, 32'h0,        0, 16'h1234, 16'h0000, 32'h10,       32'h11,       21'h12);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,        1, 16'h8001, 16'hBEEF, 32'h11,       32'h13,       21'h13);
    vecs[7]  = mk(0, 1, 0, 0, 32'h0,        1, 16'h8001, 16'hBEEF, 32'h11,       32'h13,       21'h13);
    vecs[8]  = mk(0, 1, 0, 0, 32'h0,        1, 16'h8001, 16'hBEEF, 32'h11,       32'h13,       21'h13);
    vecs[9]  = mk(0, 1, 0, 0, 32'h0,        1, 16'h8001, 16'hBEEF, 32'h11,       32'h13,       21'h13);
    vecs[10] = mk(0, 1, 0, 1, 32'h40,       0, 16'h8001, 16'hBEEF, 32'h11,       32'h13,       21'h40);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,        1, 16'h0042, 16'h0000, 32'h40,       32'h41,       21'h41);
    vecs[12] = mk(0, 0, 1, 0, 32'h0,        0, 16'h0042, 16'h0000, 32'h40,       32'h41,       21'h42);
    vecs[13] = mk(0, 1, 1, 0, 32'h0,        0, 16'h0042, 16'h0000, 32'h40,       32'h41,       21'h43);
    vecs[14] = mk(0, 0, 0, 0, 32'h0,        1, 16'h8005, 16'h1111, 32'h42,       32'h44,       21'h44);

    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].stl, vecs[i].fls, vecs[i].br, vecs[i].tgt);
      chk_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].instr, vecs[i].imm,
              vecs[i].pc, vecs[i].pcn, vecs[i].addr);
    end

    // Branch while waiting for the immediate: the 0x8001 instruction must never appear.
    step(0, 0, 0, 1, 32'h11);
    chk_va("brimm.redir", 1'b0, 21'h11);
    step(0, 0, 0, 0, 32'h0);
    chk_va("brimm.first", 1'b0, 21'h12);
    step(0, 0, 0, 1, 32'h20);
    chk_va("brimm.abort", 1'b0, 21'h20);
    step(0, 0, 0, 0, 32'h0);
    chk_all("brimm.next", 1'b1, 16'h0020, 16'h0000, 32'h20, 32'h21, 21'h21);

    // PC wrap at the top of the address space.
    step(0, 0, 0, 1, 32'hFFFF_FFFF);
    chk_va("wrap.redir", 1'b0, 21'h1F_FFFF);
    step(0, 0, 0, 0, 32'h0);
    chk_all("wrap.exec", 1'b1, 16'h0077, 16'h0000, 32'hFFFF_FFFF, 32'h0000_0000, 21'h0);

    // Reset in the middle of a two-word fetch clears everything, no partial output.
    step(0, 0, 0, 1, 32'h11);
    chk_va("rstimm.redir", 1'b0, 21'h11);
    step(0, 0, 0, 0, 32'h0);
    chk_va("rstimm.first", 1'b0, 21'h12);
    step(1, 1, 0, 1, 32'h99);
    chk_all("rstimm.reset", 1'b0, 16'h0000, 16'h0000, 32'h0, 32'h0, 21'h0);
    step(0, 0, 0, 0, 32'h0);
    chk_all("rstimm.rsthi", 1'b0, 16'h0000, 16'h0000, 32'h0, 32'h0, 21'h1);
    step(0, 0, 0, 0, 32'h0);
    chk_all("rstimm.boot", 1'b0, 16'h0000, 16'h0000, 32'h0, 32'h0, 21'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named as elsewhere in the processor:
- clk  in  1  sole clock, all state changes on rising edge
- reset  in  1  synchronous, active-high
REQ-002 Remaining ports SHALL be:
- stall  in  1  hold fetch state and IF/ID outputs
- flush  in  1  discard current IF/ID contents
- branch_taken  in  1  redirect fetch
- branch_target  in  32  new PC when branch_taken=1
- imem_addr  out  21  instruction memory word address (combinational read)
- imem_data  in  16  instruction word at imem_addr, same cycle
- ifid_valid  out  1  IF/ID holds a complete instruction
- ifid_instr  out  16  first instruction word
- ifid_imm  out  16  second word of two-word instruction, else 0
- ifid_pc  out  32  address of first word
- ifid_pc_next  out  32  address following the whole instruction

Function
REQ-003 The FSM SHALL have states RST_LO, RST_HI, FETCH, FETCH_IMM.
REQ-004 imem_addr SHALL be 0 in RST_LO, 1 in RST_HI, and PC[20:0] in FETCH and FETCH_IMM.
REQ-005 RST_LO SHALL latch imem_data into PC[31:16] and go to RST_HI.
REQ-006 RST_HI SHALL latch imem_data into PC[15:0] and go to FETCH.
REQ-007 In RST_LO/RST_HI, ifid_valid SHALL be 0, and stall, flush and branch_taken SHALL be ignored.
REQ-008 An instruction SHALL be two-word when imem_data[15]=1 in FETCH, and one-word otherwise.
REQ-009 One-word in FETCH SHALL load: ifid_instr=imem_data, ifid_imm=0, ifid_pc=PC, ifid_pc_next=PC+1, ifid_valid=1; PC<=PC+1; stay in FETCH.
REQ-010 Two-word in FETCH SHALL:
- save the first word and PC internally
- set ifid_valid<=0
- set PC<=PC+1
- go to FETCH_IMM
REQ-011 FETCH_IMM SHALL load: ifid_instr=saved word, ifid_imm=imem_data, ifid_pc=saved PC, ifid_pc_next=PC+1, ifid_valid=1; PC<=PC+1; go to FETCH.
REQ-012 Outside RST states, priority SHALL be: branch_taken > flush > stall > normal.
REQ-013 branch_taken=1 SHALL set PC<=branch_target and ifid_valid<=0, abort any FETCH_IMM, and go to FETCH.
REQ-014 flush=1 without branch_taken SHALL set ifid_valid<=0 and continue normal fetch that cycle.
REQ-015 stall=1 alone SHALL hold PC, state, saved word and all ifid_* outputs unchanged.
REQ-016 PC arithmetic SHALL be 32-bit modulo: 0xFFFFFFFF+1 = 0x00000000; imem_addr uses the low 21 bits only.
REQ-017 The block SHALL have no combinational path from imem_data to any ifid_* output; latency is one cycle for one-word and two cycles for two-word instructions.

Reset
REQ-018 reset=1 at a clock edge SHALL, regardless of other inputs, set:
- state=RST_LO, PC=0
- ifid_valid=0, ifid_instr=0, ifid_imm=0, ifid_pc=0, ifid_pc_next=0
- saved word and saved PC=0
REQ-019 Reset asserted mid-FETCH_IMM SHALL discard the pending instruction, with no partial output.

Structure
REQ-020 A shared package SHALL hold:
- the FSM state enum
- TWO_WORD_BIT=15
- RESET_VEC_HI_ADDR=0 and RESET_VEC_LO_ADDR=1
- PC width 32 and IMEM address width 21
REQ-021 The IF/ID output register bank (valid, instr, imm, pc, pc_next, with hold and clear controls) SHALL be a sub-module named if_id_reg.

Verification
REQ-022 Reset vector: M[0]=0x0000, M[1]=0x0010 -> 2 cycles after reset release, PC=0x00000010 and ifid_valid=0 throughout.
REQ-023 One-word: M[0x10]=0x1234 -> next cycle ifid_valid=1, ifid_instr=0x1234, ifid_imm=0, ifid_pc=0x10, ifid_pc_next=0x11.
REQ-024 Two-word: M[0x11]=0x8001, M[0x12]=0xBEEF -> the cycle after fetching 0x8001 has ifid_valid=0; the next has ifid_instr=0x8001, ifid_imm=0xBEEF, ifid_pc=0x11, ifid_pc_next=0x13.
REQ-025 Stall plus branch: stall=1 for 3 cycles -> outputs frozen; then stall=1 with branch_taken=1, target=0x40 -> PC=0x40, ifid_valid=0.
REQ-026 Branch in FETCH_IMM: branch_taken=1 to 0x20 while in FETCH_IMM -> no instruction 0x8001 ever presented; next valid has ifid_pc=0x20.
REQ-027 Wrap and mid-op reset: PC=0xFFFFFFFF one-word -> ifid_pc_next=0x00000000; reset during FETCH_IMM -> state=RST_LO, all outputs 0.
